ahb_interconnect: RTL
=====================

# ahb_interconnect

Parametrised single-master AHB-Lite interconnect: address-based decoder, pipelined data-phase response multiplexer and built-in default slave, for SLAVES_NUM memory-mapped slaves. It sits between one AHB master and N slaves and replaces the fixed four-slave, sideband-select arrangement. Slave selection comes from HADDR, so the address phase and data phase stay aligned per the AHB pipeline. Unmapped accesses receive a protocol-correct two-cycle ERROR response.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- SLAVES_NUM, 4, number of slaves (1..16)
- BASE_ADDR, 32'h0000_0000, start of slave 0 region
- REGION_BITS, 12, log2 of bytes per slave region (slave i covers BASE_ADDR + i·2^REGION_BITS)
- ERRCNT_WIDTH, 8, width of error counter

Ports:
- hclk  in  1  clock
- hreset  in  1  asynchronous, active-high reset
- haddr  in  ADDR_WIDTH  master address-phase address
- htrans  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- hready  out  1  global HREADY, to master and all slaves
- hrdata  out  DATA_WIDTH  read data to master
- hresp  out  1  response to master (0 OKAY, 1 ERROR)
- s_hsel  out  SLAVES_NUM  one-hot address-phase select
- s_hrdata  in  SLAVES_NUM·DATA_WIDTH  slave read data, slave i at bits [i·DW +: DW]
- s_hreadyout  in  SLAVES_NUM  slave HREADYOUT
- s_hresp  in  SLAVES_NUM  slave HRESP
- err_count  out  ERRCNT_WIDTH  saturating count of completed ERROR responses

## Operation
- Decode is combinational on haddr.
  - off = haddr − BASE_ADDR; idx = off >> REGION_BITS.
  - mapped = (haddr ≥ BASE_ADDR) && (idx < SLAVES_NUM).
  - s_hsel[idx] = mapped, regardless of htrans; all other bits are 0.
- Data-phase register dsel (slave index plus a default flag) loads the address-phase decode on every hclk edge where hready = 1. It holds while hready = 0.
- Response mux, selected by dsel:
  - A mapped slave drives hready = s_hreadyout[dsel], hresp = s_hresp[dsel], hrdata = s_hrdata slice.
  - The default slave drives hready and hresp from its FSM, and hrdata = 0.
- Default slave FSM (DS_IDLE, DS_ERR1, DS_ERR2):
  - DS_IDLE → DS_ERR1 when hready = 1, the decode is unmapped and htrans[1] = 1.
  - DS_ERR1 → DS_ERR2 unconditionally. Outputs hready = 0, hresp = 1.
  - DS_ERR2 outputs hready = 1, hresp = 1. It goes to DS_ERR1 if a new unmapped NONSEQ/SEQ is sampled, otherwise to DS_IDLE.
  - DS_IDLE outputs hready = 1, hresp = 0. Unmapped IDLE/BUSY therefore complete OKAY with zero wait.
- err_count increments on each edge where hready = 1 and hresp = 1. This covers the default slave and any slave's ERROR. The counter saturates at 2^ERRCNT_WIDTH − 1 and never wraps.

## Timing
- Reset (async assert, released on the hclk edge) sets:
  - dsel to the default slave.
  - FSM to DS_IDLE.
  - err_count to 0.
- Outputs during and after reset: hready = 1, hresp = 0, hrdata = 0. s_hsel follows haddr.
- Decode-to-s_hsel latency is 0 cycles. The response-select path lags by 1 cycle, updating on the same edge that ends the previous data phase.
- Unmapped NONSEQ completes in exactly 2 data-phase cycles: cycle 1 has hready = 0, hresp = 1; cycle 2 has hready = 1, hresp = 1.
- A slave wait state (s_hreadyout = 0) freezes dsel. The address phase pending at that moment is captured only on the edge where hready = 1.
- Back-to-back transfers to different slaves: the data phase of slave A and the address phase of slave B overlap. hsel switches immediately while the mux still selects A.
- Reset mid-transfer aborts any in-progress ERROR sequence. err_count clears; no partial count is kept.

## Test plan
- Reset: assert hreset with random haddr → hready = 1, hresp = 0, hrdata = 0, err_count = 0. After release, the first edge behaves as DS_IDLE.
- Mapped read, 4 slaves, REGION_BITS = 12:
  - NONSEQ to 0x0000_2004 → s_hsel = 4'b0100.
  - Next cycle, hrdata equals slave 2's data. hresp = 0.
  - With slave 2 stalling 3 cycles, hready stays low for exactly 3 cycles.
- Unmapped NONSEQ to 0x0000_4000 → hready low for 1 cycle, hresp = 1 for 2 cycles, err_count = 1. An IDLE to the same address gives OKAY with zero wait.
- Pipelined mix: slave 0 read, slave 3 write, unmapped, slave 1 read on consecutive cycles → each data phase returns its own slave's data. The ERROR lands only in the third data phase, and slave 1's hsel is asserted during DS_ERR2.
- Slave ERROR and saturation:
  - A slave returns a two-cycle ERROR → err_count increments once.
  - 260 unmapped NONSEQs with ERRCNT_WIDTH = 8 → err_count = 255.
- Reset asserted during DS_ERR1 → the FSM returns to DS_IDLE immediately and hready = 1 with no completed ERROR. Repeat with SLAVES_NUM = 1 and SLAVES_NUM = 16.

Source files
------------

// File: rtl/ahb_interconnect.sv
// Single-master AHB-Lite interconnect: address decoder, data-phase response mux
// and a default slave that returns the two-cycle ERROR response for unmapped transfers.
module ahb_interconnect #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           SLAVES_NUM   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int unsigned           REGION_BITS  = 12,
    parameter int unsigned           ERRCNT_WIDTH = 8
) (
    input  logic                             hclk,
    input  logic                             hreset,
    input  logic [ADDR_WIDTH-1:0]            haddr,
    input  logic [1:0]                       htrans,
    output logic                             hready,
    output logic [DATA_WIDTH-1:0]            hrdata,
    output logic                             hresp,
    output logic [SLAVES_NUM-1:0]            s_hsel,
    input  logic [SLAVES_NUM*DATA_WIDTH-1:0] s_hrdata,
    input  logic [SLAVES_NUM-1:0]            s_hreadyout,
    input  logic [SLAVES_NUM-1:0]            s_hresp,
    output logic [ERRCNT_WIDTH-1:0]          err_count
);

    localparam int unsigned IDX_W = (SLAVES_NUM > 1) ? $clog2(SLAVES_NUM) : 1;
    localparam logic [ERRCNT_WIDTH-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    typedef struct packed {
        logic             dflt;
        logic [IDX_W-1:0] idx;
    } dsel_t;

    logic [ADDR_WIDTH:0]   off_ext;
    logic [ADDR_WIDTH-1:0] region;
    logic                  mapped;
    logic [IDX_W-1:0]      idx;
    logic                  err_start;
    logic                  unused_trans_low;

    dsel_t     dsel;
    ds_state_t ds_state;
    ds_state_t ds_next;
    logic      ds_ready;
    logic      ds_resp;

    assign unused_trans_low = htrans[0];

    // Address decode; the borrow of the extended subtraction flags haddr below BASE_ADDR
    always_comb begin
        off_ext = {1'b0, haddr} - {1'b0, BASE_ADDR};
        region  = off_ext[ADDR_WIDTH-1:0] >> REGION_BITS;
        mapped  = !off_ext[ADDR_WIDTH] && (region < ADDR_WIDTH'(SLAVES_NUM));
        idx     = IDX_W'(region);
    end

    always_comb begin
        s_hsel = '0;
        for (int unsigned i = 0; i < SLAVES_NUM; i++) begin
            s_hsel[i] = mapped && (region == ADDR_WIDTH'(i));
        end
    end

    assign err_start = !mapped && htrans[1];

    // Data-phase select follows the address phase on every completed transfer
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dsel <= '{dflt: 1'b1, idx: '0};
        end else if (hready) begin
            dsel <= '{dflt: !mapped, idx: (mapped ? idx : '0)};
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            ds_state <= DS_IDLE;
        end else begin
            ds_state <= ds_next;
        end
    end

    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_IDLE: if (hready && err_start) ds_next = DS_ERR1;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = (hready && err_start) ? DS_ERR1 : DS_IDLE;
            default: ds_next = DS_IDLE;
        endcase
    end

    // Default-slave outputs decode from state alone so hready has no path back into ds_next
    assign ds_ready = (ds_state != DS_ERR1);
    assign ds_resp  = (ds_state == DS_ERR1) || (ds_state == DS_ERR2);

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        if (dsel.dflt) begin
            hready = ds_ready;
            hresp  = ds_resp;
        end else begin
            for (int unsigned i = 0; i < SLAVES_NUM; i++) begin
                if (dsel.idx == IDX_W'(i)) begin
                    hready = s_hreadyout[i];
                    hresp  = s_hresp[i];
                    hrdata = s_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Completed ERROR responses, saturating
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            err_count <= '0;
        end else if (hready && hresp && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERRCNT_WIDTH'(1);
        end
    end

endmodule
